// File: rtl/fmap_width_packer.sv
// fmap_width_packer: repacks a WIDTH_IN-bit LSB-first beat stream into
// WIDTH_OUT-bit words with valid/ready on both sides. A frame ends with
// in_last. The residual partial word is zero-padded, flushed and tagged
// with out_last.
//
// Handshake semantics (both ports): a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. in_ready depends
// combinationally on out_ready and never on in_valid. out_data, out_last
// and word_cnt stay stable while out_valid is high and out_ready is low.
module fmap_width_packer #(
  parameter int WIDTH_IN  = 256,
  parameter int WIDTH_OUT = 324,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int ACC_W  = WIDTH_IN + WIDTH_OUT - 1;
  localparam int FILL_W = $clog2(WIDTH_IN + WIDTH_OUT);
  localparam logic [FILL_W-1:0] WO_F = FILL_W'(WIDTH_OUT);
  localparam logic [FILL_W-1:0] WI_F = FILL_W'(WIDTH_IN);

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_pop;
  logic [FILL_W-1:0]    fill_q, fill_d, fill_pop;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 valid_raw, last_raw;
  logic                 in_fire, out_fire;

  // Handshake outputs. All outputs are forced to zero while rst is high so
  // nothing stale is presented during the reset cycle itself.
  always_comb begin
    valid_raw = (fill_q >= WO_F) || ((state_q == FLUSH) && (fill_q != '0));
    last_raw  = (state_q == FLUSH) && (fill_q <= WO_F) && valid_raw;
    out_valid = valid_raw & ~rst;
    out_last  = last_raw & ~rst;
    out_data  = rst ? '0 : acc_q[WIDTH_OUT-1:0];
    word_cnt  = rst ? '0 : cnt_q;
    out_fire  = out_valid & out_ready;
    // A partial last word pops fewer than WIDTH_OUT bits; clamp at zero.
    if (out_fire) begin
      fill_pop = (fill_q > WO_F) ? (fill_q - WO_F) : '0;
    end else begin
      fill_pop = fill_q;
    end
    in_ready = (state_q == PACK) && (fill_pop < WO_F) && !rst;
    in_fire  = in_valid & in_ready;
  end

  // Next-state: pop (shift out) first, then insert the new beat at the
  // post-pop fill level; handle frame start/end and the word counter.
  always_comb begin
    acc_pop = out_fire ? (acc_q >> WIDTH_OUT) : acc_q;
    acc_d   = acc_pop;
    fill_d  = fill_pop;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_fire) begin
      acc_d  = acc_pop | (ACC_W'(in_data) << fill_pop);
      fill_d = fill_pop + WI_F;
    end
    if (out_fire) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    case (state_q)
      PACK: begin
        if (in_fire && in_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_fire && out_last) begin
          state_d = PACK;
          acc_d   = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = PACK;
    endcase
  end

  // State registers with synchronous reset; partial data is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PACK;
      acc_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fmap_width_packer.sv
// tb_fmap_width_packer: three packer configurations (256->324, 324->256,
// 256->128) driven through one shared stimulus path selected by sel. The
// reference model treats the stream as a queue of bits and cuts it into
// WIDTH_OUT-bit words, zero-padding the final one.
module tb_fmap_width_packer;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [323:0] in_data;
  logic         in_valid, in_last, out_ready;
  logic [1:0]   sel;

  logic         in_ready, out_valid, out_last;
  logic [323:0] out_data;
  logic [15:0]  word_cnt;

  logic         ir_a, ov_a, ol_a, ir_b, ov_b, ol_b, ir_c, ov_c, ol_c;
  logic [323:0] od_a;
  logic [255:0] od_b;
  logic [127:0] od_c;
  logic [15:0]  wc_a, wc_b, wc_c;

  fmap_width_packer #(.WIDTH_IN(256), .WIDTH_OUT(324), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data[255:0]),
    .in_valid(in_valid & (sel == 2'd0)), .in_last(in_last), .in_ready(ir_a),
    .out_data(od_a), .out_valid(ov_a), .out_last(ol_a),
    .out_ready(out_ready & (sel == 2'd0)), .word_cnt(wc_a));

  fmap_width_packer #(.WIDTH_IN(324), .WIDTH_OUT(256), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid & (sel == 2'd1)), .in_last(in_last), .in_ready(ir_b),
    .out_data(od_b), .out_valid(ov_b), .out_last(ol_b),
    .out_ready(out_ready & (sel == 2'd1)), .word_cnt(wc_b));

  fmap_width_packer #(.WIDTH_IN(256), .WIDTH_OUT(128), .CNT_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data[255:0]),
    .in_valid(in_valid & (sel == 2'd2)), .in_last(in_last), .in_ready(ir_c),
    .out_data(od_c), .out_valid(ov_c), .out_last(ol_c),
    .out_ready(out_ready & (sel == 2'd2)), .word_cnt(wc_c));

  // route the selected instance onto the common observation signals
  always_comb begin
    in_ready  = ir_a;
    out_valid = ov_a;
    out_last  = ol_a;
    out_data  = od_a;
    word_cnt  = wc_a;
    if (sel == 2'd1) begin
      in_ready  = ir_b;
      out_valid = ov_b;
      out_last  = ol_b;
      out_data  = {68'd0, od_b};
      word_cnt  = wc_b;
    end else if (sel == 2'd2) begin
      in_ready  = ir_c;
      out_valid = ov_c;
      out_last  = ol_c;
      out_data  = {196'd0, od_c};
      word_cnt  = wc_c;
    end
  end

  // scoreboard / model state
  int           total = 0;
  int           bad   = 0;
  int           cur_wi, cur_wo;
  bit           bits_q[$];
  logic [323:0] exp_q[$];
  bit           exp_last_q[$];
  bit           flush_m;
  int           exp_cnt;
  int           beat_idx, n_beats, got_words, cyc;
  bit           got_last, take;
  bit           cnt_mode, vld_rand, rdy_rand;
  int           stall_at, stall_len;

  task automatic chk(input string tag, input logic [323:0] obs, input logic [323:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [323:0] make_beat(input int k);
    logic [323:0] d;
    logic [31:0]  kv;
    d  = '0;
    kv = k;
    for (int j = 0; j < cur_wi; j++) begin
      d[j] = cnt_mode ? kv[j % 32] : 1'($urandom_range(0, 1));
    end
    return d;
  endfunction

  // cut whole words from the bit stream; on frame end pad the residue
  task automatic form_words(input bit fin);
    logic [323:0] w;
    int           n;
    while (bits_q.size() >= cur_wo) begin
      w = '0;
      for (int j = 0; j < cur_wo; j++) w[j] = bits_q.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(fin && (bits_q.size() == 0));
    end
    if (fin && (bits_q.size() > 0)) begin
      w = '0;
      n = bits_q.size();
      for (int j = 0; j < n; j++) w[j] = bits_q.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(1'b1);
    end
  endtask

  task automatic clear_model();
    bits_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    flush_m   = 1'b0;
    exp_cnt   = 0;
    beat_idx  = 0;
    got_words = 0;
    got_last  = 1'b0;
    take      = 1'b0;
  endtask

  // driver: called just after a rising edge; holds an offered beat until taken
  task automatic drive();
    if (take) begin
      in_valid = 1'b0;
      take     = 1'b0;
    end
    if (!in_valid) begin
      if ((beat_idx < n_beats) && (!vld_rand || ($urandom_range(0, 3) != 0))) begin
        in_valid = 1'b1;
        in_data  = make_beat(beat_idx + 1);
        in_last  = (beat_idx == n_beats - 1);
      end else begin
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
      end
    end
    if ((cyc >= stall_at) && (cyc < stall_at + stall_len)) out_ready = 1'b0;
    else out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // one cycle: check outputs at the falling edge, advance model, drive next
  task automatic step();
    bit of, inf, l, exp_ir;
    int fill_m;
    @(negedge clk);
    fill_m = exp_q.size() * cur_wo + bits_q.size();
    of     = out_valid && out_ready;
    inf    = in_valid && in_ready;
    chk("out_valid", {323'd0, out_valid}, {323'd0, (exp_q.size() > 0)});
    if (out_valid && (exp_q.size() > 0)) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_last", {323'd0, out_last}, {323'd0, exp_last_q[0]});
      chk("word_cnt", {308'd0, word_cnt}, 324'(exp_cnt));
    end
    exp_ir = !flush_m && ((fill_m - (of ? cur_wo : 0)) < cur_wo);
    chk("in_ready", {323'd0, in_ready}, {323'd0, exp_ir});
    if (of && (exp_q.size() > 0)) begin
      l = exp_last_q.pop_front();
      void'(exp_q.pop_front());
      got_words++;
      if (l) begin
        got_last = 1'b1;
        flush_m  = 1'b0;
        exp_cnt  = 0;
      end else begin
        exp_cnt = (exp_cnt + 1) % 65536;
      end
    end
    if (inf) begin
      for (int j = 0; j < cur_wi; j++) bits_q.push_back(in_data[j]);
      beat_idx++;
      take = 1'b1;
      if (in_last) flush_m = 1'b1;
      form_words(in_last);
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_frame(input int s, input int wi, input int wo, input int nb,
                           input int nw, input bit cm, input bit vr, input bit rr,
                           input int st_at, input int st_len, input int abort_after);
    sel       = 2'(s);
    cur_wi    = wi;
    cur_wo    = wo;
    n_beats   = nb;
    cnt_mode  = cm;
    vld_rand  = vr;
    rdy_rand  = rr;
    stall_at  = st_at;
    stall_len = st_len;
    cyc       = 0;
    clear_model();
    in_valid  = 1'b0;
    drive();
    while (!got_last && (cyc < 5000) && !((abort_after > 0) && (beat_idx >= abort_after)))
      step();
    if (abort_after > 0) begin
      chk("abort_beats", 324'(beat_idx), 324'(abort_after));
    end else begin
      chk("frame_done", {323'd0, got_last}, 324'd1);
      chk("word_count", 324'(got_words), 324'(nw));
      @(negedge clk);
      chk("post_valid", {323'd0, out_valid}, 324'd0);
      chk("post_cnt", {308'd0, word_cnt}, 324'd0);
      chk("post_ready", {323'd0, in_ready}, 324'd1);
      @(posedge clk);
      #1;
    end
  endtask

  // hold rst for n cycles, then check the cycle after it drops
  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_valid", {323'd0, out_valid}, 324'd0);
      chk("rst_last", {323'd0, out_last}, 324'd0);
      chk("rst_data", out_data, 324'd0);
      chk("rst_cnt", {308'd0, word_cnt}, 324'd0);
      chk("rst_ready", {323'd0, in_ready}, 324'd0);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("postrst_valid", {323'd0, out_valid}, 324'd0);
    chk("postrst_data", out_data, 324'd0);
    chk("postrst_cnt", {308'd0, word_cnt}, 324'd0);
    chk("postrst_ready", {323'd0, in_ready}, 324'd1);
    @(posedge clk);
    #1;
    clear_model();
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 2'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cur_wi    = 256;
    cur_wo    = 324;
    do_reset(2);
    // 81 counting beats -> 64 words, no pad
    run_frame(0, 256, 324, 81, 64, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    // 3 beats -> 3 words, last one padded above bit 119
    run_frame(0, 256, 324, 3, 3, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    // 10-cycle stall mid-frame, then random backpressure
    run_frame(0, 256, 324, 81, 64, 1'b1, 1'b0, 1'b1, 20, 10, 0);
    // 324 -> 256: 64 beats -> 81 words
    run_frame(1, 324, 256, 64, 81, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    // 256 -> 128: one beat -> 2 words, no third pad word
    run_frame(2, 256, 128, 1, 2, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_frame(2, 256, 128, 5, 10, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    // reset mid-frame after 10 beats, then a fresh full frame
    run_frame(0, 256, 324, 81, 64, 1'b1, 1'b0, 1'b0, 0, 0, 10);
    do_reset(1);
    run_frame(0, 256, 324, 81, 64, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
